// File: rtl/axi_wr_arb_pkg.sv
// Shared types and helpers for the AXI write-port arbiter.
// No logic; constants only.
// Not applicable.
package axi_wr_arb_pkg;

    // The captured AW entry is sized for the widest supported configuration.
    // The top zero-fills and slices it down to the instance widths.
    localparam int AXI_ADDR_MAX = 64;
    localparam int AXI_LEN_W    = 8;
    localparam int AXI_ID_MAX   = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        AW_OUT = 1'b1
    } aw_state_e;

    typedef struct packed {
        logic [AXI_ADDR_MAX-1:0] addr;
        logic [AXI_LEN_W-1:0]    len;
        logic [AXI_ID_MAX-1:0]   id;
    } aw_entry_t;

    // Requester-index width: clog2(n) with a floor of one bit.
    function automatic int idx_w(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_wr_arb_order_fifo.sv
// Order FIFO holding the requester index of each AW-granted burst.
// Latency: a push is visible at the head on the following cycle.
// Backpressure: o_full blocks pushes; a pop on an empty FIFO is ignored.
module axi_wr_arb_order_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic [W-1:0] i_push_dat,
    input  logic         i_pop,
    output logic [W-1:0] o_head_dat,
    output logic         o_full,
    output logic         o_empty
);

    localparam int PW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PW:0]  r_wr_ptr;
    logic [PW:0]  r_rd_ptr;
    logic [W-1:0] r_mem [DEPTH];

    assign o_empty    = (r_wr_ptr == r_rd_ptr);
    assign o_full     = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                        (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign o_head_dat = r_mem[r_rd_ptr[PW-1:0]];

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (i_push && !o_full) begin
            r_mem[r_wr_ptr[PW-1:0]] <= i_push_dat;
        end
    end

    // Pointer update; push and pop in the same cycle are both honoured.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push && !o_full) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop && !o_empty) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Shares one wide AXI write port among NUM_REQ requesters (RR AW, ordered W, indexed B); QoS via AXI_WR_ARB_QOS_EN.
// Latency: requester AW accept at cycle N gives m_awvalid at N+1; W and B paths are combinational.
// Backpressure: AW held until m_awready; no AW accepted while order FIFO full; W/B ready passed straight through.
module axi_wr_arbiter
    import axi_wr_arb_pkg::*;
#(
    parameter int  NUM_REQ    = 2,
    parameter int  ADDR_W     = 32,
    parameter int  DATA_W     = 64,
    parameter int  ID_W       = 4,
    parameter int  FIFO_DEPTH = 4,
    localparam int IDX_W      = idx_w(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_awvalid,
    output logic [NUM_REQ-1:0]         req_awready,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_awaddr,
    input  logic [NUM_REQ*8-1:0]       req_awlen,
    input  logic [NUM_REQ*ID_W-1:0]    req_awid,
`ifdef AXI_WR_ARB_QOS_EN
    input  logic [NUM_REQ*4-1:0]       req_awqos,
    output logic [3:0]                 m_awqos,
`endif
    input  logic [NUM_REQ-1:0]         req_wvalid,
    input  logic [NUM_REQ-1:0]         req_wlast,
    output logic [NUM_REQ-1:0]         req_wready,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
    input  logic [NUM_REQ*DATA_W/8-1:0] req_wstrb,
    output logic [NUM_REQ-1:0]         req_bvalid,
    input  logic [NUM_REQ-1:0]         req_bready,
    output logic [1:0]                 req_bresp,
    output logic [ID_W-1:0]            req_bid,
    output logic                       m_awvalid,
    input  logic                       m_awready,
    output logic [ADDR_W-1:0]          m_awaddr,
    output logic [7:0]                 m_awlen,
    output logic [ID_W+IDX_W-1:0]      m_awid,
    output logic                       m_wvalid,
    input  logic                       m_wready,
    output logic                       m_wlast,
    output logic [DATA_W-1:0]          m_wdata,
    output logic [DATA_W/8-1:0]        m_wstrb,
    input  logic                       m_bvalid,
    output logic                       m_bready,
    input  logic [ID_W+IDX_W-1:0]      m_bid,
    input  logic [1:0]                 m_bresp,
    output logic                       bid_err
);

    localparam int MID_W = ID_W + IDX_W;
    localparam int STB_W = DATA_W / 8;

    aw_state_e        r_state;
    aw_state_e        w_state_nxt;
    aw_entry_t        r_aw;
    aw_entry_t        w_aw_nxt;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic [IDX_W-1:0] w_cand;
    logic             w_cand_vld;
    int               w_scan;
    logic [IDX_W-1:0] w_scan_idx;
    logic             w_accept;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_fifo_pop;
    logic [IDX_W-1:0] w_head;
    logic [IDX_W-1:0] w_bidx;
    logic             w_bidx_ok;
    logic             r_bid_err;
    logic             w_unused_aw;
`ifdef AXI_WR_ARB_QOS_EN
    logic [3:0]       w_best_qos;
    logic [3:0]       r_awqos;
`endif

    // Candidate search starting at the RR pointer; with QoS the highest level wins and the earliest in RR order breaks ties.
    always_comb begin
        w_cand_vld = 1'b0;
        w_cand     = '0;
        w_scan     = 0;
        w_scan_idx = '0;
`ifdef AXI_WR_ARB_QOS_EN
        w_best_qos = '0;
`endif
        for (int o = 0; o < NUM_REQ; o++) begin
            w_scan = int'(r_rr_ptr) + o;
            if (w_scan >= NUM_REQ) begin
                w_scan = w_scan - NUM_REQ;
            end
            w_scan_idx = w_scan[IDX_W-1:0];
`ifdef AXI_WR_ARB_QOS_EN
            if (req_awvalid[w_scan_idx] &&
                (!w_cand_vld || (req_awqos[w_scan_idx*4 +: 4] > w_best_qos))) begin
                w_cand_vld = 1'b1;
                w_cand     = w_scan_idx;
                w_best_qos = req_awqos[w_scan_idx*4 +: 4];
            end
`else
            if (req_awvalid[w_scan_idx] && !w_cand_vld) begin
                w_cand_vld = 1'b1;
                w_cand     = w_scan_idx;
            end
`endif
        end
    end

    assign w_ptr_nxt = (int'(w_cand) == NUM_REQ - 1) ? '0 : w_cand + 1'b1;

    // AW FSM next state, requester ready and capture of the winning AW.
    always_comb begin
        w_state_nxt = r_state;
        w_aw_nxt    = r_aw;
        w_accept    = 1'b0;
        req_awready = '0;
        case (r_state)
            IDLE: begin
                if (w_cand_vld && !w_fifo_full) begin
                    w_accept                 = 1'b1;
                    req_awready[w_cand]      = 1'b1;
                    w_state_nxt              = AW_OUT;
                    w_aw_nxt                 = '0;
                    w_aw_nxt.addr[ADDR_W-1:0] = req_awaddr[w_cand*ADDR_W +: ADDR_W];
                    w_aw_nxt.len             = req_awlen[w_cand*8 +: 8];
                    w_aw_nxt.id[MID_W-1:0]   = {w_cand, req_awid[w_cand*ID_W +: ID_W]};
                end
            end
            AW_OUT: begin
                if (m_awready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // AW state, output register stage and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_aw     <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_aw    <= w_aw_nxt;
            if (w_accept) begin
                r_rr_ptr <= w_ptr_nxt;
            end
        end
    end

`ifdef AXI_WR_ARB_QOS_EN
    // Winner's QoS is captured alongside the other AW fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_awqos <= '0;
        end else if (w_accept) begin
            r_awqos <= req_awqos[w_cand*4 +: 4];
        end
    end

    assign m_awqos = r_awqos;
`endif

    assign m_awvalid   = (r_state == AW_OUT);
    assign m_awaddr    = r_aw.addr[ADDR_W-1:0];
    assign m_awlen     = r_aw.len;
    assign m_awid      = r_aw.id[MID_W-1:0];
    // Upper entry bits exist only for wider builds and are always zero here.
    assign w_unused_aw = ^r_aw;

    axi_wr_arb_order_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (IDX_W)
    ) u_order_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_accept),
        .i_push_dat (w_cand),
        .i_pop      (w_fifo_pop),
        .o_head_dat (w_head),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty)
    );

    // W steering: only the requester at the FIFO head reaches the wide port.
    always_comb begin
        m_wvalid   = 1'b0;
        m_wlast    = 1'b0;
        m_wdata    = '0;
        m_wstrb    = '0;
        req_wready = '0;
        if (!w_fifo_empty) begin
            m_wvalid           = req_wvalid[w_head];
            m_wlast            = req_wlast[w_head];
            m_wdata            = req_wdata[w_head*DATA_W +: DATA_W];
            m_wstrb            = req_wstrb[w_head*STB_W +: STB_W];
            req_wready[w_head] = m_wready;
        end
    end

    assign w_fifo_pop = m_wvalid & m_wready & m_wlast;

    assign w_bidx    = m_bid[MID_W-1:ID_W];
    assign w_bidx_ok = (int'(w_bidx) < NUM_REQ);
    assign req_bid   = m_bid[ID_W-1:0];
    assign req_bresp = m_bresp;

    // B steering by the index in the upper ID bits; unknown indices are sunk.
    always_comb begin
        req_bvalid = '0;
        m_bready   = 1'b1;
        if (w_bidx_ok) begin
            req_bvalid[w_bidx] = m_bvalid;
            m_bready           = req_bready[w_bidx];
        end
    end

    // Sticky flag for responses whose index matches no requester.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bid_err <= 1'b0;
        end else if (m_bvalid && !w_bidx_ok) begin
            r_bid_err <= 1'b1;
        end
    end

    assign bid_err = r_bid_err;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter with hand-computed expectations.
// Three requesters so that B index 3 is representable and out of range.
// Inputs driven 1 ns after the rising edge, outputs sampled a further 1-2 ns later.
module tb_axi_wr_arbiter;

    localparam int NUM_REQ    = 3;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 64;
    localparam int ID_W       = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int IDX_W      = 2;
    localparam int MID_W      = ID_W + IDX_W;

    logic                        clk;
    logic                        reset;
    logic [NUM_REQ-1:0]          req_awvalid;
    logic [NUM_REQ-1:0]          req_awready;
    logic [NUM_REQ*ADDR_W-1:0]   req_awaddr;
    logic [NUM_REQ*8-1:0]        req_awlen;
    logic [NUM_REQ*ID_W-1:0]     req_awid;
`ifdef AXI_WR_ARB_QOS_EN
    logic [NUM_REQ*4-1:0]        req_awqos;
    logic [3:0]                  m_awqos;
`endif
    logic [NUM_REQ-1:0]          req_wvalid;
    logic [NUM_REQ-1:0]          req_wlast;
    logic [NUM_REQ-1:0]          req_wready;
    logic [NUM_REQ*DATA_W-1:0]   req_wdata;
    logic [NUM_REQ*DATA_W/8-1:0] req_wstrb;
    logic [NUM_REQ-1:0]          req_bvalid;
    logic [NUM_REQ-1:0]          req_bready;
    logic [1:0]                  req_bresp;
    logic [ID_W-1:0]             req_bid;
    logic                        m_awvalid;
    logic                        m_awready;
    logic [ADDR_W-1:0]           m_awaddr;
    logic [7:0]                  m_awlen;
    logic [MID_W-1:0]            m_awid;
    logic                        m_wvalid;
    logic                        m_wready;
    logic                        m_wlast;
    logic [DATA_W-1:0]           m_wdata;
    logic [DATA_W/8-1:0]         m_wstrb;
    logic                        m_bvalid;
    logic                        m_bready;
    logic [MID_W-1:0]            m_bid;
    logic [1:0]                  m_bresp;
    logic                        bid_err;

    int n_checks;
    int n_fails;

    axi_wr_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .ID_W       (ID_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_awvalid (req_awvalid),
        .req_awready (req_awready),
        .req_awaddr  (req_awaddr),
        .req_awlen   (req_awlen),
        .req_awid    (req_awid),
`ifdef AXI_WR_ARB_QOS_EN
        .req_awqos   (req_awqos),
        .m_awqos     (m_awqos),
`endif
        .req_wvalid  (req_wvalid),
        .req_wlast   (req_wlast),
        .req_wready  (req_wready),
        .req_wdata   (req_wdata),
        .req_wstrb   (req_wstrb),
        .req_bvalid  (req_bvalid),
        .req_bready  (req_bready),
        .req_bresp   (req_bresp),
        .req_bid     (req_bid),
        .m_awvalid   (m_awvalid),
        .m_awready   (m_awready),
        .m_awaddr    (m_awaddr),
        .m_awlen     (m_awlen),
        .m_awid      (m_awid),
        .m_wvalid    (m_wvalid),
        .m_wready    (m_wready),
        .m_wlast     (m_wlast),
        .m_wdata     (m_wdata),
        .m_wstrb     (m_wstrb),
        .m_bvalid    (m_bvalid),
        .m_bready    (m_bready),
        .m_bid       (m_bid),
        .m_bresp     (m_bresp),
        .bid_err     (bid_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs;
        req_awvalid = '0;
        req_awaddr  = '0;
        req_awlen   = '0;
        req_awid    = '0;
`ifdef AXI_WR_ARB_QOS_EN
        req_awqos   = '0;
`endif
        req_wvalid  = '0;
        req_wlast   = '0;
        req_wdata   = '0;
        req_wstrb   = '1;
        req_bready  = '0;
        m_awready   = 1'b0;
        m_wready    = 1'b0;
        m_bvalid    = 1'b0;
        m_bid       = '0;
        m_bresp     = '0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        clr_inputs();
        tick();
        tick();
        check_eq("rst_m_awvalid", m_awvalid, 0);
        check_eq("rst_awready", req_awready, 0);
        check_eq("rst_m_wvalid", m_wvalid, 0);
        check_eq("rst_bid_err", bid_err, 0);
        check_eq("rst_m_awaddr", m_awaddr, 0);
        check_eq("rst_m_awid", m_awid, 0);
        reset = 1'b0;
    endtask

    int exp_g [4] = '{0, 1, 0, 1};

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset    = 1'b1;
        clr_inputs();

        // Single requester AW plus 4-beat burst.
        do_reset();
        req_awvalid          = 3'b001;
        req_awaddr[0 +: 32]  = 32'h1000;
        req_awlen[0 +: 8]    = 8'd3;
        req_awid[0 +: 4]     = 4'd5;
        #1;
        check_eq("t1_awready", req_awready, 3'b001);
        tick();
        req_awvalid = '0;
        #1;
        check_eq("t1_m_awvalid", m_awvalid, 1);
        check_eq("t1_m_awaddr", m_awaddr, 32'h1000);
        check_eq("t1_m_awlen", m_awlen, 3);
        check_eq("t1_m_awid", m_awid, 6'h05);
        check_eq("t1_no_awready_out", req_awready, 0);
        tick();
        check_eq("t1_m_awvalid_held", m_awvalid, 1);
        m_awready = 1'b1;
        tick();
        m_awready = 1'b0;
        #1;
        check_eq("t1_m_awvalid_done", m_awvalid, 0);
        m_wready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            req_wvalid         = 3'b001;
            req_wdata[0 +: 64] = 64'hA0 + 64'(b);
            req_wlast          = (b == 3) ? 3'b001 : 3'b000;
            #1;
            check_eq("t1_m_wvalid", m_wvalid, 1);
            check_eq("t1_m_wdata", m_wdata, 64'hA0 + 64'(b));
            check_eq("t1_m_wlast", m_wlast, (b == 3) ? 1 : 0);
            check_eq("t1_wready", req_wready, 3'b001);
            tick();
        end
        req_wlast = '0;
        #1;
        check_eq("t1_empty_wvalid", m_wvalid, 0);
        check_eq("t1_empty_wready", req_wready, 0);

        // Round-robin between req0 and req1, then W in grant order.
        do_reset();
        req_awvalid          = 3'b011;
        req_awaddr[0 +: 32]  = 32'h100;
        req_awaddr[32 +: 32] = 32'h200;
        req_awid[0 +: 4]     = 4'd1;
        req_awid[4 +: 4]     = 4'd2;
        m_awready            = 1'b1;
        for (int r = 0; r < 4; r++) begin
            #1;
            check_eq("t2_grant", req_awready, 3'(1 << exp_g[r]));
            tick();
            #1;
            check_eq("t2_m_awid", m_awid, (exp_g[r] == 1) ? 6'h12 : 6'h01);
            tick();
        end
        req_awvalid          = '0;
        m_awready            = 1'b0;
        req_wvalid           = 3'b011;
        req_wlast            = 3'b011;
        req_wdata[0 +: 64]   = 64'h0D;
        req_wdata[64 +: 64]  = 64'h1D;
        m_wready             = 1'b1;
        for (int r = 0; r < 4; r++) begin
            #1;
            check_eq("t2_w_order", m_wdata, (exp_g[r] == 1) ? 64'h1D : 64'h0D);
            check_eq("t2_w_ready", req_wready, 3'(1 << exp_g[r]));
            tick();
        end
        #1;
        check_eq("t2_drained", m_wvalid, 0);

        // FIFO full blocks the fifth AW, even in the cycle that pops.
        do_reset();
        m_awready   = 1'b1;
        req_awvalid = 3'b001;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("t3_accept", req_awready, 3'b001);
            tick();
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            #1;
            check_eq("t3_full_block", req_awready, 0);
            tick();
        end
        req_wvalid = 3'b001;
        req_wlast  = 3'b001;
        m_wready   = 1'b1;
        #1;
        check_eq("t3_pop_wvalid", m_wvalid, 1);
        check_eq("t3_block_on_pop", req_awready, 0);
        tick();
        req_wvalid = '0;
        m_wready   = 1'b0;
        #1;
        check_eq("t3_accept_after_pop", req_awready, 3'b001);
        tick();
        req_awvalid = '0;

        // W from req1 is held off until its AW is granted.
        do_reset();
        req_wvalid          = 3'b010;
        req_wlast           = 3'b010;
        req_wdata[64 +: 64] = 64'h55;
        m_wready            = 1'b1;
        #1;
        check_eq("t4_early_wvalid", m_wvalid, 0);
        check_eq("t4_early_wready", req_wready, 0);
        tick();
        #1;
        check_eq("t4_early_wready2", req_wready, 0);
        req_awvalid      = 3'b010;
        req_awid[4 +: 4] = 4'd3;
        #1;
        check_eq("t4_aw_grant", req_awready, 3'b010);
        check_eq("t4_push_not_yet", m_wvalid, 0);
        tick();
        req_awvalid = '0;
        #1;
        check_eq("t4_wvalid", m_wvalid, 1);
        check_eq("t4_wready", req_wready, 3'b010);
        check_eq("t4_wdata", m_wdata, 64'h55);
        tick();
        req_wvalid = '0;
        m_awready  = 1'b1;
        tick();
        m_awready  = 1'b0;

        // B routing with backpressure, then an out-of-range index.
        do_reset();
        m_bvalid = 1'b1;
        m_bid    = 6'h13;
        m_bresp  = 2'b10;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("t5_bvalid_held", req_bvalid, 3'b010);
            check_eq("t5_bid", req_bid, 3);
            check_eq("t5_bready_low", m_bready, 0);
            tick();
        end
        check_eq("t5_bresp", req_bresp, 2'b10);
        req_bready = 3'b010;
        #1;
        check_eq("t5_bready_hs", m_bready, 1);
        tick();
        req_bready = '0;
        m_bid      = 6'h37;
        #1;
        check_eq("t5_sink_bready", m_bready, 1);
        check_eq("t5_sink_bvalid", req_bvalid, 0);
        check_eq("t5_err_not_yet", bid_err, 0);
        tick();
        m_bvalid = 1'b0;
        #1;
        check_eq("t5_bid_err", bid_err, 1);
        tick();
        check_eq("t5_bid_err_sticky", bid_err, 1);

        // Reset while the AW output stage is occupied.
        do_reset();
        req_awvalid          = 3'b100;
        req_awaddr[64 +: 32] = 32'h3000;
        #1;
        check_eq("t6_grant2", req_awready, 3'b100);
        tick();
        req_awvalid = '0;
        #1;
        check_eq("t6_aw_out", m_awvalid, 1);
        check_eq("t6_aw_addr", m_awaddr, 32'h3000);
        reset = 1'b1;
        tick();
        check_eq("t6_rst_awvalid", m_awvalid, 0);
        req_wvalid = 3'b100;
        req_wlast  = 3'b100;
        m_wready   = 1'b1;
        #1;
        check_eq("t6_fifo_empty_wready", req_wready, 0);
        check_eq("t6_fifo_empty_wvalid", m_wvalid, 0);
        reset = 1'b0;

`ifdef AXI_WR_ARB_QOS_EN
        // Higher QoS wins regardless of the round-robin pointer.
        do_reset();
        req_awqos[0 +: 4] = 4'd2;
        req_awqos[4 +: 4] = 4'd9;
        req_awvalid       = 3'b011;
        #1;
        check_eq("q_grant", req_awready, 3'b010);
        tick();
        req_awvalid = '0;
        #1;
        check_eq("q_m_awqos", m_awqos, 9);
        check_eq("q_m_awid_idx", m_awid[MID_W-1:ID_W], 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
